// File: rtl/dti_arbiter.sv
// Round-robin N:1 valid/ready arbiter with one registered output stage; dout_data = {source index, payload}.
// Optional packet locking (payload MSB = end-of-transfer) is built when DTI_ARBITER_LOCK_EN is defined.
module dti_arbiter #(
  parameter int NUM = 2,
  parameter int DIN = 16,
  localparam int CTRL_W = $clog2(NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM-1:0]        din_valid,
  output logic [NUM-1:0]        din_ready,
  input  logic [NUM*DIN-1:0]    din_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DIN+CTRL_W-1:0] dout_data
);

  logic                  out_valid_q;
  logic [DIN+CTRL_W-1:0] out_data_q;
  logic [CTRL_W-1:0]     last_grant_q;
  logic                  accept;
  logic                  handshake;
  logic [NUM-1:0]        eligible;
  logic                  grant_found;
  logic [CTRL_W-1:0]     grant_idx;
  logic [CTRL_W-1:0]     cand;
  logic [DIN-1:0]        din_word [NUM];
  logic [DIN-1:0]        sel_word;

`ifdef DTI_ARBITER_LOCK_EN
  logic lock_q;
`endif

  assign accept    = !out_valid_q | dout_ready;
  assign handshake = !rst & accept & grant_found;
  assign sel_word  = din_word[grant_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_lane
      assign din_word[gi] = din_data[gi*DIN +: DIN];
`ifdef DTI_ARBITER_LOCK_EN
      // The lock owner is always the last winner, so no separate owner register is needed.
      assign eligible[gi] = din_valid[gi] & (!lock_q | (last_grant_q == CTRL_W'(gi)));
`else
      assign eligible[gi] = din_valid[gi];
`endif
      assign din_ready[gi] = handshake & (grant_idx == CTRL_W'(gi));
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    // k = NUM lands back on the last winner, so a lone requester is served every accept cycle.
    for (int k = 1; k <= NUM; k++) begin
      cand = CTRL_W'((int'(last_grant_q) + k) % NUM);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      last_grant_q <= CTRL_W'(NUM - 1);
    end else if (accept) begin
      out_valid_q <= grant_found;
      if (grant_found) begin
        last_grant_q <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      out_data_q <= {grant_idx, sel_word};
    end
  end

`ifdef DTI_ARBITER_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (handshake) begin
      lock_q <= !sel_word[DIN-1];
    end
  end
`endif

  assign dout_valid = out_valid_q;
  assign dout_data  = out_data_q;

endmodule
